core_done_collector: RTL and testbench

CORE_DONE_COLLECTOR -- requirements
Module: core_done_collector

---
 rtl/core_done_collector_if.sv | 26 ++
 rtl/core_done_collector.sv | 137 +++++++++++++
 tb/tb_core_done_collector.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/core_done_collector_if.sv
// Host/core handshake bundle for core_done_collector: job launch, per-core done pulses, status.
interface core_done_collector_if #(
  parameter int unsigned NUM_CORES = 4
);
  localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);

  logic                 start;
  logic [NUM_CORES-1:0] cpu_done;
  logic                 ack;
  logic                 core_start;
  logic                 busy;
  logic [NUM_CORES-1:0] done_mask;
  logic [CNT_W-1:0]     done_count;
  logic                 all_done;
  logic                 timeout;

  modport master (
    output start, cpu_done, ack,
    input  core_start, busy, done_mask, done_count, all_done, timeout
  );

  modport slave (
    input  start, cpu_done, ack,
    output core_start, busy, done_mask, done_count, all_done, timeout
  );
endinterface

// File: rtl/core_done_collector.sv
// Collects per-core completion pulses for one launched job and reports all-done to the host.
// Optional RUN watchdog enabled by defining CORE_DONE_TIMEOUT_EN.
module core_done_collector #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  core_done_collector_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TMO} state_e;

  if (NUM_CORES < 2 || NUM_CORES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("core_done_collector: unsupported NUM_CORES/TIMEOUT_CYCLES");
  end

  state_e               state_q, state_d;
  logic                 core_start_q, core_start_d;
  logic                 busy_q, busy_d;
  logic                 all_done_q, all_done_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_CORES-1:0] new_bits;
  logic [NUM_CORES-1:0] mask_upd;
  logic [CNT_W-1:0]     new_cnt;

`ifdef CORE_DONE_TIMEOUT_EN
  localparam int unsigned      WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  // Only first reports from cores not yet in the mask contribute to this cycle's update.
  always_comb begin
    new_bits = bus.cpu_done & ~mask_q;
    mask_upd = mask_q | new_bits;
    new_cnt  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      new_cnt = new_cnt + CNT_W'(new_bits[i]);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    mask_d       = mask_q;
    count_d      = count_q;
`ifdef CORE_DONE_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_RUN;
          core_start_d = 1'b1;
          mask_d       = '0;
          count_d      = '0;
`ifdef CORE_DONE_TIMEOUT_EN
          wd_d         = '0;
`endif
        end
      end
      S_RUN: begin
        mask_d  = mask_upd;
        count_d = count_q + new_cnt;
        // Completion takes priority over a coincident watchdog expiry.
        if (&mask_upd) begin
          state_d = S_DONE;
        end
`ifdef CORE_DONE_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d = S_TMO;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_DONE, S_TMO: begin
        if (bus.ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d == S_RUN);
    all_done_d = (state_d == S_DONE);
`ifdef CORE_DONE_TIMEOUT_EN
    timeout_d  = (state_d == S_TMO);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      mask_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
    end
  end

`ifdef CORE_DONE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.core_start = core_start_q;
  assign bus.busy       = busy_q;
  assign bus.all_done   = all_done_q;
  assign bus.done_mask  = mask_q;
  assign bus.done_count = count_q;

endmodule

// File: tb/tb_core_done_collector.sv
// Directed plus randomized bench for core_done_collector against a job-level reference model.
module tb_core_done_collector;
  localparam int unsigned NC  = 4;
  localparam int unsigned TMO = 20;
`ifdef CORE_DONE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;
  localparam int P_TMO  = 3;

  logic clk;
  logic reset;

  core_done_collector_if #(.NUM_CORES(NC)) bus ();

  core_done_collector #(
    .NUM_CORES      (NC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: which cores have reported in the current job, and job phase.
  int m_list[$];
  int m_phase;
  int m_cycles;
  bit m_cs;

  function automatic bit reported(int c);
    foreach (m_list[k]) if (m_list[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (m_list[k]) m = m | (32'd1 << m_list[k]);
    return m;
  endfunction

  task automatic model_reset();
    m_list.delete();
    m_phase  = P_IDLE;
    m_cycles = 0;
    m_cs     = 1'b0;
  endtask

  task automatic model_edge(input bit st, input logic [NC-1:0] cd, input bit ak);
    m_cs = 1'b0;
    if (m_phase == P_IDLE) begin
      if (st) begin
        m_phase  = P_RUN;
        m_list.delete();
        m_cycles = 0;
        m_cs     = 1'b1;
      end
    end else if (m_phase == P_RUN) begin
      for (int i = 0; i < NC; i++) begin
        if (cd[i] && !reported(i)) m_list.push_back(i);
      end
      m_cycles++;
      if (m_list.size() == NC) m_phase = P_DONE;
      else if (TMO_EN && m_cycles == TMO) m_phase = P_TMO;
    end else if (ak) begin
      m_phase = P_IDLE;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".core_start"}, 32'(bus.core_start), 32'(m_cs));
    chk({tag, ".busy"},       32'(bus.busy),       32'(m_phase == P_RUN));
    chk({tag, ".done_mask"},  32'(bus.done_mask),  model_mask());
    chk({tag, ".done_count"}, 32'(bus.done_count), 32'(m_list.size()));
    chk({tag, ".all_done"},   32'(bus.all_done),   32'(m_phase == P_DONE));
    chk({tag, ".timeout"},    32'(bus.timeout),    32'(m_phase == P_TMO));
  endtask

  task automatic step(input bit st, input logic [NC-1:0] cd, input bit ak, input string tag);
    bus.start    = st;
    bus.cpu_done = cd;
    bus.ack      = ak;
    @(posedge clk);
    model_edge(st, cd, ak);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.cpu_done = '0;
    bus.ack      = 1'b0;
    model_reset();
    #3 check_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Pulses in IDLE and acks outside DONE are ignored.
    step(1'b0, 4'b1111, 1'b1, "idle_ignore");
    step(1'b0, 4'b0101, 1'b0, "idle_ignore");

    // Sequential single-core reports.
    step(1'b1, 4'b0000, 1'b0, "seq_start");
    for (int i = 0; i < NC; i++) step(1'b0, NC'(1 << i), 1'b0, "seq_core");
    step(1'b0, 4'b0000, 1'b1, "seq_ack");

    // Simultaneous reports, then a repeat in DONE.
    step(1'b1, 4'b0000, 1'b0, "multi_start");
    step(1'b0, 4'b1011, 1'b0, "multi_1011");
    step(1'b0, 4'b0100, 1'b0, "multi_0100");
    step(1'b0, 4'b0010, 1'b0, "multi_repeat");

    // DONE held without ack; start ignored, including with ack.
    for (int i = 0; i < 10; i++) step(i == 4, 4'b0000, 1'b0, "hold_done");
    step(1'b1, 4'b0000, 1'b1, "ack_with_start");
    step(1'b0, 4'b0000, 1'b0, "idle_retained");
    step(1'b1, 4'b0000, 1'b0, "restart_clears");

    // Report coincident with core_start, repeat within RUN, then async reset mid-RUN.
    step(1'b0, 4'b0011, 1'b0, "run_0011");
    step(1'b0, 4'b0001, 1'b0, "run_repeat");
    async_reset("mid_run_reset");
    step(1'b0, 4'b1111, 1'b0, "post_reset_ignore");
    step(1'b0, 4'b1000, 1'b1, "post_reset_ignore");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0,
           ($urandom_range(0, 2) == 0) ? NC'($urandom) : NC'(0),
           $urandom_range(0, 3) == 0, "rand");
    end

    // Watchdog: only core 0 reports.
    async_reset("pre_wd_reset");
    step(1'b1, 4'b0000, 1'b0, "wd_start");
    step(1'b0, 4'b0001, 1'b0, "wd_core0");
    for (int i = 0; i < 24; i++) step(1'b0, 4'b0000, 1'b0, "wd_wait");
    step(1'b0, 4'b0010, 1'b0, "wd_frozen");
    step(1'b0, 4'b0000, 1'b1, "wd_ack");

    // Final report lands on the watchdog expiry edge.
    async_reset("pre_race_reset");
    step(1'b1, 4'b0000, 1'b0, "race_start");
    step(1'b0, 4'b0111, 1'b0, "race_0111");
    for (int i = 0; i < 18; i++) step(1'b0, 4'b0000, 1'b0, "race_wait");
    step(1'b0, 4'b1000, 1'b0, "race_last");
    step(1'b0, 4'b0000, 1'b1, "race_ack");

    if (n_pass + n_fail != n_total) $fatal(1, "check counter inconsistency");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
